// File: rtl/rsa_xcel_mont_pkg.sv
// Shared definitions for the Montgomery multiplier slice: default operand
// width and the multiplier FSM state encoding.
package rsa_xcel_mont_pkg;

  // Default operand / modulus width; R = 2^MONT_NBITS.
  localparam int MONT_NBITS = 32;

  // Multiplier control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mont_state_e;

endpackage

// File: rtl/rsa_xcel_mont_mont_mul_rem_dpath.sv
// Datapath of the radix-2 Montgomery multiplier: operand registers, the
// accumulator S, the bit counter, the add/shift step and the final subtract.
// S carries two extra bits: with S < 2^(p_nbits+1) on entry, S + b + n always
// fits in p_nbits+2 bits, so no step can overflow even for out-of-range operands.
module rsa_xcel_mont_mont_mul_rem_dpath
  import rsa_xcel_mont_pkg::*;
#(
  parameter int p_nbits = MONT_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  input  logic [p_nbits-1:0] in_n,
  output logic               last_step,
  output logic [p_nbits-1:0] result
);

  localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
  localparam int SW = p_nbits + 2;

  logic [p_nbits-1:0] a_q;
  logic [p_nbits-1:0] b_q;
  logic [p_nbits-1:0] n_q;
  logic [SW-1:0]      s_q;
  logic [CW-1:0]      i_q;

  logic [SW-1:0] s_add;
  logic [SW-1:0] s_odd;
  logic [SW-1:0] s_step;
  logic [SW-1:0] s_fix;
  logic [SW-1:0] n_ext;

  // One Montgomery step and the final conditional subtract, both combinational.
  always_comb begin
    n_ext  = {2'b00, n_q};
    s_add  = s_q + ({SW{a_q[i_q]}} & {2'b00, b_q});
    s_odd  = s_add + (s_add[0] ? n_ext : '0);
    s_step = {1'b0, s_odd[SW-1:1]};
    s_fix  = (s_q >= n_ext) ? (s_q - n_ext) : s_q;
  end

  // Operand capture, accumulator and bit-counter updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
      s_q <= '0;
      i_q <= '0;
    end else if (load) begin
      a_q <= in_a;
      b_q <= in_b;
      n_q <= in_n;
      s_q <= '0;
      i_q <= '0;
    end else if (step) begin
      s_q <= s_step;
      i_q <= i_q + CW'(1);
    end else if (fix) begin
      s_q <= s_fix;
    end
  end

  assign last_step = (i_q == CW'(p_nbits - 1));
  assign result    = s_q[p_nbits-1:0];

endmodule

// File: rtl/rsa_xcel_mont_mont_mul_rem.sv
// Radix-2 Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^p_nbits.
// Handshakes: a transfer happens on a rising clk edge where val and rdy are
// both 1; rdy/val outputs are pure functions of the state register, and a
// producer may hold val high across cycles without side effects.
// Fixed latency: accept in cycle T, result valid from cycle T+p_nbits+2.
module rsa_xcel_mont_mont_mul_rem
  import rsa_xcel_mont_pkg::*;
#(
  parameter int p_nbits = MONT_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] istream_a,
  input  logic [p_nbits-1:0] istream_b,
  input  logic [p_nbits-1:0] istream_n,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg,
  output logic [1:0]         dbg_state
);

  mont_state_e state_q;
  mont_state_e state_d;
  logic        load;
  logic        step;
  logic        fix;
  logic        last_step;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: CALC runs until the counter's last bit, FIX is one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (istream_val) state_d = ST_CALC;
      ST_CALC: if (last_step)   state_d = ST_FIX;
      ST_FIX:                   state_d = ST_DONE;
      ST_DONE: if (ostream_rdy) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from the current state.
  always_comb begin
    istream_rdy = (state_q == ST_IDLE);
    ostream_val = (state_q == ST_DONE);
    load        = (state_q == ST_IDLE) && istream_val;
    step        = (state_q == ST_CALC);
    fix         = (state_q == ST_FIX);
  end

  assign dbg_state = state_q;

  rsa_xcel_mont_mont_mul_rem_dpath #(.p_nbits(p_nbits)) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .in_a      (istream_a),
    .in_b      (istream_b),
    .in_n      (istream_n),
    .last_step (last_step),
    .result    (ostream_msg)
  );

endmodule

// File: tb/tb_rsa_xcel_mont_mont_mul_rem.sv
// Bench for the Montgomery multiplier: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_rsa_xcel_mont_mont_mul_rem;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk;
  logic         reset;
  logic         istream_val;
  logic         istream_rdy;
  logic [W-1:0] istream_a;
  logic [W-1:0] istream_b;
  logic [W-1:0] istream_n;
  logic         ostream_val;
  logic         ostream_rdy;
  logic [W-1:0] ostream_msg;
  logic [1:0]   dbg_state;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] exp;
  } vec_t;

  rsa_xcel_mont_mont_mul_rem dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_a   (istream_a),
    .istream_b   (istream_b),
    .istream_n   (istream_n),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .dbg_state   (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a*b*R^-1 mod n, with R^-1 = ((n+1)/2)^W mod n (inverse of 2 raised to W).
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    longint unsigned nn, half, rinv, ab;
    nn   = 64'(n);
    half = (nn + 1) / 2;
    rinv = 1;
    for (int k = 0; k < W; k++) rinv = (rinv * half) % nn;
    ab = (64'(a) * 64'(b)) % nn;
    return W'((ab * rinv) % nn);
  endfunction

  // Driver: one full operation; holds ostream_rdy low for 'hold' DONE cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                        input int hold, input string tag,
                        output logic [W-1:0] res, output int lat);
    int w;
    logic [W-1:0] held;
    w = 0;
    while (!istream_rdy && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_accept_rdy"}, W'(istream_rdy), W'(1));
    istream_val = 1'b1;
    istream_a   = a;
    istream_b   = b;
    istream_n   = n;
    @(posedge clk); #1;
    istream_val = 1'b0;
    istream_a   = $urandom;
    istream_b   = $urandom;
    istream_n   = $urandom;
    lat = 1;
    while (!ostream_val && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (lat == 5) begin
        istream_a = $urandom;
        istream_n = $urandom;
      end
    end
    chk({tag, "_latency"}, W'(lat), W'(LAT));
    held = ostream_msg;
    for (int k = 0; k < hold; k++) begin
      chk({tag, "_bp_val"}, W'(ostream_val), W'(1));
      chk({tag, "_bp_irdy"}, W'(istream_rdy), W'(0));
      chk({tag, "_bp_msg"}, ostream_msg, held);
      @(posedge clk); #1;
    end
    res = ostream_msg;
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
    chk({tag, "_idle_rdy"}, W'(istream_rdy), W'(1));
    chk({tag, "_idle_val"}, W'(ostream_val), W'(0));
  endtask

  initial begin
    vec_t vecs[6];
    logic [W-1:0] res;
    logic [W-1:0] ra, rb, rn;
    int lat;
    int seen;
    int nacc, nres, c;
    int acc_c[2];
    int cons_c[2];
    logic [W-1:0] bres[2];

    total = 0;
    bad   = 0;
    vecs[0] = '{a: 32'd1,          b: 32'd1,          n: 32'd13,         exp: 32'd3};
    vecs[1] = '{a: 32'd9,          b: 32'd9,          n: 32'd13,         exp: 32'd9};
    vecs[2] = '{a: 32'd12,         b: 32'd12,         n: 32'd13,         exp: 32'd3};
    vecs[3] = '{a: 32'd0,          b: 32'd7,          n: 32'd13,         exp: 32'd0};
    vecs[4] = '{a: 32'd2,          b: 32'd3,          n: 32'hFFFFFFFF,   exp: 32'd6};
    vecs[5] = '{a: 32'hFFFFFFFE,   b: 32'hFFFFFFFE,   n: 32'hFFFFFFFF,   exp: 32'd1};

    // Reset block.
    istream_val = 1'b0;
    istream_a   = '0;
    istream_b   = '0;
    istream_n   = '0;
    ostream_rdy = 1'b0;
    reset       = 1'b0;
    #2;
    chk("rst_val", W'(ostream_val), W'(0));
    chk("rst_msg", ostream_msg, '0);
    chk("rst_state", W'(dbg_state), W'(0));
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_irdy", W'(istream_rdy), W'(1));

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].n, 0, $sformatf("vec%0d", i), res, lat);
      chk($sformatf("vec%0d_msg", i), res, vecs[i].exp);
    end

    // Backpressure: five cycles of ostream_rdy low in DONE.
    run_op(32'd9, 32'd9, 32'd13, 5, "bp", res, lat);
    chk("bp_msg_final", res, 32'd9);

    // Reset in the middle of CALC discards the operation.
    istream_val = 1'b1;
    istream_a   = 32'd5;
    istream_b   = 32'd6;
    istream_n   = 32'd13;
    @(posedge clk); #1;
    istream_val = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midrst_in_calc", W'(dbg_state), W'(1));
    #1 reset = 1'b0;
    #1;
    chk("midrst_async_state", W'(dbg_state), W'(0));
    chk("midrst_async_val", W'(ostream_val), W'(0));
    chk("midrst_async_msg", ostream_msg, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_irdy", W'(istream_rdy), W'(1));
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (ostream_val) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_val", W'(seen), W'(0));
    run_op(32'd1, 32'd1, 32'd13, 0, "postrst", res, lat);
    chk("postrst_msg", res, 32'd3);

    // Back-to-back with istream_val and ostream_rdy held high.
    istream_val = 1'b1;
    istream_a   = 32'd1;
    istream_b   = 32'd1;
    istream_n   = 32'd13;
    ostream_rdy = 1'b1;
    nacc = 0;
    nres = 0;
    c    = 0;
    acc_c[0] = -1; acc_c[1] = -1; cons_c[0] = -1; cons_c[1] = -1;
    bres[0] = '0; bres[1] = '0;
    while (nres < 2 && c < 300) begin
      if (istream_rdy && istream_val && nacc < 2) begin
        acc_c[nacc] = c;
        nacc++;
      end
      if (ostream_val) begin
        bres[nres]   = ostream_msg;
        cons_c[nres] = c;
        nres++;
      end
      @(posedge clk); #1;
      c++;
      if (nacc == 1) begin
        istream_a = 32'd9;
        istream_b = 32'd9;
      end
      if (nacc == 2) istream_val = 1'b0;
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    chk("b2b_count", W'(nres), W'(2));
    chk("b2b_res0", bres[0], 32'd3);
    chk("b2b_res1", bres[1], 32'd9);
    chk("b2b_gap", W'(acc_c[1]), W'(cons_c[0] + 1));
    chk("b2b_lat0", W'(cons_c[0] - acc_c[0]), W'(LAT));

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      rn = $urandom | 32'd1;
      if (rn == 32'd1) rn = 32'd3;
      if (i < 3) rn = W'($urandom_range(3, 255)) | 32'd1;
      ra = $urandom % rn;
      rb = $urandom % rn;
      exp_q.push_back(model(ra, rb, rn));
      run_op(ra, rb, rn, $urandom_range(0, 2), $sformatf("rnd%0d", i), res, lat);
      if (exp_q.size() > 0) chk($sformatf("rnd%0d_msg", i), res, exp_q.pop_front());
    end

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_xcel_mont_mont_mul_rem.md
RSA_XCEL_MONT_MONT_MUL_REM -- requirements
Module: rsa_xcel_mont_mont_mul_rem

Interface
REQ-001 Parameter: p_nbits, 32, operand/modulus width in bits; R = 2^p_nbits.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 istream_val  input  1  operand message valid.
REQ-005 istream_rdy  output  1  unit can accept an operand message.
REQ-006 istream_a  input  p_nbits  multiplicand a, a < n.
REQ-007 istream_b  input  p_nbits  multiplier b, b < n.
REQ-008 istream_n  input  p_nbits  modulus n, odd, n > 1.
REQ-009 ostream_val  output  1  result valid.
REQ-010 ostream_rdy  input  1  consumer accepts result.
REQ-011 ostream_msg  output  p_nbits  result = a*b*R^-1 mod n.

Function
REQ-012 The unit SHALL be an FSM with states IDLE, CALC, FIX and DONE.
REQ-013 istream_rdy SHALL be 1 only in IDLE, and ostream_val SHALL be 1 only in DONE; neither SHALL depend combinationally on any input.
REQ-014 IDLE to CALC SHALL occur on istream_val & istream_rdy:
- latch a, b, n;
- clear accumulator S (p_nbits+2 bits);
- clear bit counter i.
REQ-015 Each CALC cycle SHALL perform one radix-2 Montgomery step:
- S = S + a[i]*b;
- if S odd, S = S + n;
- S = S >> 1;
- i = i + 1.
REQ-016 CALC SHALL last exactly p_nbits cycles, then transition to FIX.
REQ-017 FIX SHALL, in one cycle, subtract n from S if S >= n and transition to DONE; the result SHALL be the low p_nbits of S.
REQ-018 Latency SHALL be fixed: handshake in cycle T gives ostream_val = 1 from cycle T+p_nbits+2 (T+34 at default).
REQ-019 In DONE, ostream_msg SHALL hold stable while ostream_rdy = 0; DONE SHALL go to IDLE on ostream_rdy = 1.
REQ-020 A new operand SHALL NOT be accepted in the same cycle a result is consumed; the earliest next accept is the following cycle (IDLE).
REQ-021 Input values SHALL be ignored outside the IDLE handshake; changes to istream_a, istream_b or istream_n mid-operation SHALL NOT affect the result.
REQ-022 Internal arithmetic SHALL be wide enough that S never overflows (S < 2n holds before FIX).
REQ-023 Behaviour for even n or operands >= n is unspecified, but the unit SHALL still complete in the fixed latency and return to IDLE.

Reset
REQ-024 On reset = 0, the unit SHALL immediately, regardless of clock, set:
- state = IDLE;
- S = 0 and i = 0;
- ostream_msg = 0;
- ostream_val = 0;
- istream_rdy = 1 after release.
REQ-025 Reset asserted mid-CALC, mid-FIX or in DONE SHALL discard the operation; no ostream_val pulse SHALL follow.

Structure
REQ-026 The state encoding (IDLE=0, CALC=1, FIX=2, DONE=3, 2 bits) SHALL live in the shared package rsa_xcel_mont_pkg.
REQ-027 The default width constant (32) SHALL live in the shared package rsa_xcel_mont_pkg.
REQ-028 The datapath (operand regs, S, counter, add/shift, final subtract) SHALL be one sub-module, rsa_xcel_mont_mont_mul_rem_dpath; the FSM SHALL stay in the top module.
REQ-029 The unit SHALL be directly instantiable as either the r or the b multiplier driven by rsa_xcel_mont_MontModExpMulCtrl; its val/rdy semantics SHALL match that controller's mulrem ports.

Verification
REQ-030 n=13, a=1, b=1 -> ostream_msg=3 (R^-1 mod 13 = 3), ostream_val asserted exactly 34 cycles after the accept.
REQ-031 n=13, a=9, b=9 -> 9; n=13, a=12, b=12 -> 3; n=13, a=0, b=7 -> 0.
REQ-032 n=0xFFFFFFFF, a=2, b=3 -> 6; n=0xFFFFFFFF, a=0xFFFFFFFE, b=0xFFFFFFFE -> 1.
REQ-033 Backpressure: ostream_rdy held 0 for 5 cycles in DONE -> ostream_val=1 and ostream_msg stable throughout, istream_rdy=0.
REQ-034 Reset pulsed low at cycle 10 of CALC -> ostream_val never asserted; istream_rdy=1 after release; the next op (n=13, a=1, b=1) returns 3.
REQ-035 Back-to-back: two ops with istream_val held 1 and ostream_rdy held 1 -> results 3 then 9, with the second accept exactly one cycle after the first result is consumed.
